// File: rtl/mdu_ctrl_if.sv
// Handshake and result bus between the EX stage (master) and the HI/LO
// multiply-divide controller (slave).
`timescale 1ns/1ps
interface mdu_ctrl_if;
  logic        Start;
  logic [5:0]  Funct;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic        Busy;
  logic        Done;
  logic        Stall;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic [31:0] MfData;

  modport master (
    output Start, Funct, Rdata1, Rdata2,
    input  Busy, Done, Stall, Hi, Lo, MfData
  );

  modport slave (
    input  Start, Funct, Rdata1, Rdata2,
    output Busy, Done, Stall, Hi, Lo, MfData
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply, 32-step
// restoring divide, one sign-fix cycle. Define MDU_SIGNED_EN for signed MULT/DIV.
`timescale 1ns/1ps
module mdu_ctrl (
  input  logic       CLK,
  input  logic       RST,
  mdu_ctrl_if.slave  bus
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state_reg, state_next;
  logic [63:0] acc_reg, acc_next;
  logic [31:0] opb_reg, opb_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;

  logic        funct_valid;
  logic        busy;
  logic        accept;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [64:0] div_shift;
  logic [32:0] div_trial;
  logic [63:0] div_step;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign funct_valid = (bus.Funct == F_MFHI) || (bus.Funct == F_MTHI) ||
                       (bus.Funct == F_MFLO) || (bus.Funct == F_MTLO) ||
                       (bus.Funct == F_MULT) || (bus.Funct == F_MULTU) ||
                       (bus.Funct == F_DIV)  || (bus.Funct == F_DIVU);

  assign busy   = (state_reg == MUL) || (state_reg == DIV) || (state_reg == FIX);
  assign accept = bus.Start && funct_valid && ((state_reg == IDLE) || (state_reg == DONE));

`ifdef MDU_SIGNED_EN
  logic res_neg_reg, res_neg_next;
  logic rem_neg_reg, rem_neg_next;
  logic op_div_reg, op_div_next;
  logic signed_op;
  logic a_neg;
  logic b_neg;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign signed_op = (bus.Funct == F_MULT) || (bus.Funct == F_DIV);
  assign a_neg     = signed_op && bus.Rdata1[31];
  assign b_neg     = signed_op && bus.Rdata2[31];
  assign a_mag     = a_neg ? (~bus.Rdata1 + 32'd1) : bus.Rdata1;
  assign b_mag     = b_neg ? (~bus.Rdata2 + 32'd1) : bus.Rdata2;

  // Product/quotient take the XOR of operand signs, remainder follows the dividend.
  assign prod_fix = res_neg_reg ? (~acc_reg + 64'd1) : acc_reg;
  assign quot_fix = res_neg_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
  assign rem_fix  = rem_neg_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
  assign fix_hi   = op_div_reg ? rem_fix  : prod_fix[63:32];
  assign fix_lo   = op_div_reg ? quot_fix : prod_fix[31:0];
`else
  assign a_mag  = bus.Rdata1;
  assign b_mag  = bus.Rdata2;
  assign fix_hi = acc_reg[63:32];
  assign fix_lo = acc_reg[31:0];
`endif

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opb_reg} : 33'd0);
  assign mul_step = {mul_sum, acc_reg[31:1]};

  // Divide: acc holds {partial remainder, dividend/quotient bits}.
  assign div_shift = {acc_reg, 1'b0};
  assign div_trial = div_shift[64:32] - {1'b0, opb_reg};
  assign div_step  = div_trial[32] ? div_shift[63:0]
                                   : {div_trial[31:0], div_shift[31:1], 1'b1};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      acc_reg     <= 64'd0;
      opb_reg     <= 32'd0;
      cnt_reg     <= 6'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
`ifdef MDU_SIGNED_EN
      res_neg_reg <= 1'b0;
      rem_neg_reg <= 1'b0;
      op_div_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      opb_reg     <= opb_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
`ifdef MDU_SIGNED_EN
      res_neg_reg <= res_neg_next;
      rem_neg_reg <= rem_neg_next;
      op_div_reg  <= op_div_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    opb_next   = opb_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
`ifdef MDU_SIGNED_EN
    res_neg_next = res_neg_reg;
    rem_neg_next = rem_neg_reg;
    op_div_next  = op_div_reg;
`endif

    case (state_reg)
      MUL: begin
        acc_next = mul_step;
        cnt_next = cnt_reg + 6'd1;
        if (cnt_reg == 6'd31) state_next = FIX;
      end
      DIV: begin
        acc_next = div_step;
        cnt_next = cnt_reg + 6'd1;
        if (cnt_reg == 6'd31) state_next = FIX;
      end
      FIX: begin
        hi_next    = fix_hi;
        lo_next    = fix_lo;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = state_reg;
    endcase

    // A new instruction is taken in IDLE or DONE; it overrides DONE -> IDLE.
    if (accept) begin
      case (bus.Funct)
        F_MTHI: hi_next = bus.Rdata2;
        F_MTLO: lo_next = bus.Rdata2;
        F_MULT, F_MULTU: begin
          opb_next   = a_mag;
          acc_next   = {32'd0, b_mag};
          cnt_next   = 6'd0;
          state_next = MUL;
`ifdef MDU_SIGNED_EN
          res_neg_next = a_neg ^ b_neg;
          rem_neg_next = 1'b0;
          op_div_next  = 1'b0;
`endif
        end
        F_DIV, F_DIVU: begin
          cnt_next = 6'd0;
          if (bus.Rdata2 == 32'd0) begin
            // Divide by zero skips iteration; FIX writes the raw dividend.
            acc_next   = {bus.Rdata1, 32'hFFFF_FFFF};
            state_next = FIX;
`ifdef MDU_SIGNED_EN
            res_neg_next = 1'b0;
            rem_neg_next = 1'b0;
            op_div_next  = 1'b1;
`endif
          end else begin
            opb_next   = b_mag;
            acc_next   = {32'd0, a_mag};
            state_next = DIV;
`ifdef MDU_SIGNED_EN
            res_neg_next = a_neg ^ b_neg;
            rem_neg_next = a_neg;
            op_div_next  = 1'b1;
`endif
          end
        end
        default: state_next = (state_reg == DONE) ? IDLE : state_reg;
      endcase
    end
  end

  assign bus.Busy   = busy;
  assign bus.Done   = (state_reg == DONE);
  assign bus.Stall  = bus.Start && funct_valid && busy;
  assign bus.Hi     = hi_reg;
  assign bus.Lo     = lo_reg;
  assign bus.MfData = (bus.Funct == F_MFHI) ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: driver pushes expected results computed with
// plain arithmetic; a negedge monitor checks timing, stalls and results.
`timescale 1ns/1ps
module tb_mdu_ctrl;

  localparam logic [5:0] T_MFHI  = 6'h10;
  localparam logic [5:0] T_MTHI  = 6'h11;
  localparam logic [5:0] T_MFLO  = 6'h12;
  localparam logic [5:0] T_MTLO  = 6'h13;
  localparam logic [5:0] T_MULT  = 6'h18;
  localparam logic [5:0] T_MULTU = 6'h19;
  localparam logic [5:0] T_DIV   = 6'h1A;
  localparam logic [5:0] T_DIVU  = 6'h1B;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mdu_ctrl_if bus();
  mdu_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        done_q[$];
  logic [31:0] mf_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          cyc    = 0;
  bit          mon_en = 1'b0;
  logic [5:0]  funct_tab [9];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      passes++;
    end
  endtask

  function automatic bit is_valid(input logic [5:0] f);
    return (f == T_MFHI) || (f == T_MTHI) || (f == T_MFLO) || (f == T_MTLO) ||
           (f == T_MULT) || (f == T_MULTU) || (f == T_DIV) || (f == T_DIVU);
  endfunction

  function automatic bit is_arith(input logic [5:0] f);
    return (f == T_MULT) || (f == T_MULTU) || (f == T_DIV) || (f == T_DIVU);
  endfunction

  // Reference model: architectural effect of one instruction.
  task automatic model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    bit          sgn;
    logic [63:0] p;
    longint      sa, sb, q, r;
`ifdef MDU_SIGNED_EN
    sgn = (f == T_MULT) || (f == T_DIV);
`else
    sgn = 1'b0;
`endif
    e.lat = 34;
    case (f)
      T_MTHI: m_hi = b;
      T_MTLO: m_lo = b;
      T_MFHI: mf_q.push_back(m_hi);
      T_MFLO: mf_q.push_back(m_lo);
      T_MULT, T_MULTU: begin
        if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
        else     p = 64'(a) * 64'(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      T_DIV, T_DIVU: begin
        if (b == 32'd0) begin
          m_hi  = a;
          m_lo  = 32'hFFFF_FFFF;
          e.lat = 2;
        end else if (sgn) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q  = sa / sb;
          r  = sa % sb;
          m_lo = 32'(q);
          m_hi = 32'(r);
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      default: ;
    endcase
    if (is_arith(f)) begin
      e.hi = m_hi;
      e.lo = m_lo;
      done_q.push_back(e);
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 after the instruction is taken.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    bit taken;
    model_op(f, a, b);
    bus.Start  = 1'b1;
    bus.Funct  = f;
    bus.Rdata1 = a;
    bus.Rdata2 = b;
    stalls = 0;
    taken  = 1'b0;
    while (!taken) begin
      @(negedge CLK);
      if (!bus.Stall) taken = 1'b1;
      else begin
        stalls++;
        if (stalls > 100) begin
          chk("issue_timeout", 64'(stalls), 64'd0);
          taken = 1'b1;
        end
      end
    end
    @(posedge CLK);
    #1;
    bus.Start = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.Start = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: expected Busy/Done timing derived from acceptance cycle and latency.
  initial begin : monitor
    bit   pending;
    int   acc_cyc;
    int   lat;
    bit   exp_busy;
    bit   exp_done;
    exp_t e;
    pending = 1'b0;
    acc_cyc = 0;
    lat     = 34;
    forever begin
      @(negedge CLK);
      if (RST) begin
        pending = 1'b0;
      end else if (mon_en) begin
        exp_busy = pending && (cyc > acc_cyc) && (cyc < acc_cyc + lat);
        exp_done = pending && (cyc == acc_cyc + lat);
        chk("busy", 64'(bus.Busy), 64'(exp_busy));
        chk("done", 64'(bus.Done), 64'(exp_done));
        if (exp_done) begin
          pending = 1'b0;
          if (done_q.size() == 0) chk("done_q_underflow", 64'd1, 64'd0);
          else begin
            e = done_q.pop_front();
            $display("done  cycle %0d: Hi=%h Lo=%h (exp %h %h)", cyc, bus.Hi, bus.Lo, e.hi, e.lo);
            chk("hi", 64'(bus.Hi), 64'(e.hi));
            chk("lo", 64'(bus.Lo), 64'(e.lo));
          end
        end
        if (bus.Start) begin
          chk("stall", 64'(bus.Stall), 64'(is_valid(bus.Funct) && exp_busy));
          if (is_valid(bus.Funct) && !bus.Stall) begin
            if (bus.Funct == T_MFHI || bus.Funct == T_MFLO) begin
              if (mf_q.size() == 0) chk("mf_q_underflow", 64'd1, 64'd0);
              else begin
                $display("mf    cycle %0d: funct=%h MfData=%h", cyc, bus.Funct, bus.MfData);
                chk("mfdata", 64'(bus.MfData), 64'(mf_q.pop_front()));
              end
            end else if (is_arith(bus.Funct)) begin
              pending = 1'b1;
              acc_cyc = cyc;
              lat     = (done_q.size() != 0) ? done_q[0].lat : 34;
              $display("start cycle %0d: funct=%h a=%h b=%h", cyc, bus.Funct, bus.Rdata1, bus.Rdata2);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int         st;
    int         dcount;
    logic [5:0] f;
    logic [31:0] a, b;
    funct_tab = '{T_MFHI, T_MTHI, T_MFLO, T_MTLO, T_MULT, T_MULTU, T_DIV, T_DIVU, 6'h2A};

    // Reset with a simultaneous Start: reset wins.
    RST        = 1'b1;
    bus.Start  = 1'b1;
    bus.Funct  = T_MULTU;
    bus.Rdata1 = 32'd5;
    bus.Rdata2 = 32'd7;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy",  64'(bus.Busy),  64'd0);
    chk("rst_done",  64'(bus.Done),  64'd0);
    chk("rst_stall", 64'(bus.Stall), 64'd0);
    chk("rst_hi",    64'(bus.Hi),    64'd0);
    chk("rst_lo",    64'(bus.Lo),    64'd0);
    @(posedge CLK);
    #1;
    RST       = 1'b0;
    bus.Start = 1'b0;
    mon_en    = 1'b1;
    idle(2);

    // Full-scale unsigned product, with MFLO arriving 10 cycles after Start.
    issue(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
    idle(9);
    issue(T_MFLO, 32'd0, 32'd0, st);
    chk("mflo_stall_cycles", 64'(st), 64'd24);
    issue(T_MFHI, 32'd0, 32'd0, st);
    chk("multu_hi_const", 64'(m_hi), 64'hFFFF_FFFE);

    // Signed/unsigned division and divide by zero.
    issue(T_DIV, 32'hFFFF_FFF9, 32'd2, st);
    idle(36);
    issue(T_DIVU, 32'd100, 32'd7, st);
    idle(36);
    issue(T_DIVU, 32'h0000_1234, 32'd0, st);
    idle(3);
    issue(T_MFLO, 32'd0, 32'd0, st);
    issue(T_MFHI, 32'd0, 32'd0, st);

    // Direct HI/LO writes and an unrecognised funct.
    issue(T_MTHI, 32'd0, 32'hDEAD_BEEF, st);
    @(negedge CLK);
    chk("mthi_hi", 64'(bus.Hi), 64'hDEAD_BEEF);
    @(posedge CLK);
    #1;
    issue(T_MTLO, 32'd0, 32'h0BAD_F00D, st);
    @(negedge CLK);
    chk("mtlo_lo", 64'(bus.Lo), 64'h0BAD_F00D);
    @(posedge CLK);
    #1;
    issue(6'h00, 32'd9, 32'd9, st);
    issue(T_MFHI, 32'd0, 32'd0, st);
    issue(T_MFLO, 32'd0, 32'd0, st);

    // Reset 15 cycles into a multiply, with a competing Start.
    issue(T_MULT, 32'h1234_5678, 32'h9ABC_DEF0, st);
    idle(14);
    RST        = 1'b1;
    bus.Start  = 1'b1;
    bus.Funct  = T_MULTU;
    bus.Rdata1 = 32'd3;
    bus.Rdata2 = 32'd3;
    done_q.delete();
    mf_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge CLK);
    #1;
    RST       = 1'b0;
    bus.Start = 1'b0;
    @(negedge CLK);
    chk("abort_busy", 64'(bus.Busy), 64'd0);
    chk("abort_hi",   64'(bus.Hi),   64'd0);
    chk("abort_lo",   64'(bus.Lo),   64'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.Done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    @(posedge CLK);
    #1;

    // Randomised traffic, including back-to-back and stalled requests.
    for (int n = 0; n < 70; n++) begin
      f = funct_tab[$urandom_range(0, 8)];
      a = rnd_val();
      b = rnd_val();
      if ((f == T_DIV || f == T_DIVU) && $urandom_range(0, 5) == 0) b = 32'd0;
      issue(f, a, b, st);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end

    idle(40);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    chk("mf_q_empty",   64'(mf_q.size()),   64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST  in  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-003 SHALL have port Start  in  1  EX stage presents an HI/LO-class instruction this cycle.
REQ-004 SHALL have port Funct  in  6  R-type funct field: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
REQ-005 SHALL have port Rdata1  in  32  rs operand (multiplicand / dividend).
REQ-006 SHALL have port Rdata2  in  32  rt operand (multiplier / divisor; MTHI/MTLO source).
REQ-007 SHALL have port Busy  out  1  iterative operation in progress.
REQ-008 SHALL have port Done  out  1  one-cycle pulse; HI/LO hold the new result.
REQ-009 SHALL have port Stall  out  1  pipeline must hold the current instruction.
REQ-010 SHALL have port Hi  out  32  architectural HI register.
REQ-011 SHALL have port Lo  out  32  architectural LO register.
REQ-012 SHALL have port MfData  out  32  MFHI ? Hi : Lo, combinational, valid when Stall=0.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, FIX, DONE.
REQ-014 SHALL accept Start only in IDLE or DONE; Start with Funct outside REQ-004 list SHALL be ignored, with no state change.
REQ-015 MULT/MULTU accepted: latch operand magnitudes and result signs, clear 6-bit counter, go to MUL; DIV/DIVU go to DIV.
REQ-016 MUL SHALL perform one shift-add step per cycle into a 64-bit accumulator for exactly 32 cycles, then go to FIX.
REQ-017 DIV SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, then go to FIX.
REQ-018 FIX SHALL apply sign correction (product negated if signs differ; quotient sign = sign XOR, remainder sign = dividend sign), write HI/LO, then go to DONE.
REQ-019 Latency: Start sampled in cycle 0 -> Busy=1 cycles 1..33 -> Done=1 and new Hi/Lo visible in cycle 34.
REQ-020 DONE SHALL last one cycle, Busy=0, then IDLE unless a new Start is accepted in DONE.
REQ-021 Divisor zero: SHALL skip iteration, go directly to FIX, and write LO=32'hFFFFFFFF, HI=Rdata1 (uncorrected); Done appears in cycle 2.
REQ-022 MTHI/MTLO accepted in IDLE/DONE SHALL write Rdata2 to Hi/Lo at the next edge, with no Busy or Done.
REQ-023 Stall SHALL equal Start AND Busy for any REQ-004 funct; stalled Start SHALL not alter state, operands or Hi/Lo.
REQ-024 MFHI/MFLO with Busy=0 SHALL not stall; MfData in Done cycle SHALL reflect the new result.
REQ-025 Hi/Lo SHALL change only on FIX exit, MTHI/MTLO, or reset.

Reset
REQ-026 RST SHALL force IDLE and clear Hi, Lo, counter and accumulator to 0; Busy=0, Done=0, Stall=0 combinationally from reset state.
REQ-027 RST asserted mid-MUL/DIV SHALL abort the operation without writing Hi/Lo; Done SHALL not pulse.
REQ-028 RST SHALL take priority over a simultaneous Start.

Configuration
REQ-029 Macro MDU_SIGNED_EN defined: MULT/DIV SHALL be signed per REQ-018.
REQ-030 MDU_SIGNED_EN undefined: MULT/DIV SHALL behave identically to MULTU/DIVU; no sign logic SHALL be synthesized; FIX still consumes one cycle (latency unchanged).

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> cycle 34 Done=1, Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-032 MDU_SIGNED_EN, DIV -7 / 2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); DIVU 100/7 -> Lo=14, Hi=2.
REQ-033 DIVU 0x1234 / 0 -> Done in cycle 2, Lo=0xFFFFFFFF, Hi=0x00001234.
REQ-034 MULT running, MFLO Start at cycle 10 -> Stall=1 cycles 10..33, Stall=0 cycle 34 with MfData = new Lo.
REQ-035 MULT running, RST at cycle 15 -> next cycle IDLE, Hi=Lo=0, no Done pulse.
REQ-036 MTHI 0xDEADBEEF then MTLO 0x0BADF00D in IDLE -> Hi/Lo updated each next edge, Busy and Done never asserted.
